// File: rtl/image_buffer_master.sv
// Buffer initiator: writes one camera frame into the pixel buffer, then streams it back out.
// Optional IMG_BUF_MIRROR_EN: read back each line horizontally mirrored.
module image_buffer_master #(
  parameter int CAMERA_HSIZE   = 4,
  parameter int CAMERA_VSIZE   = 2,
  parameter int PIXEL_SIZE     = 8,
  parameter int BUF_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic [PIXEL_SIZE-1:0]     pix_in_data,
  input  logic                      pix_in_valid,
  output logic                      pix_in_ready,
  output logic [PIXEL_SIZE-1:0]     pix_out_data,
  output logic                      pix_out_valid,
  input  logic                      pix_out_ready,
  output logic [BUF_ADDR_WIDTH-1:0] buf_waddr,
  output logic [PIXEL_SIZE-1:0]     buf_wdata,
  output logic                      buf_wvalid,
  input  logic                      buf_wready,
  output logic [BUF_ADDR_WIDTH-1:0] buf_raddr,
  output logic                      buf_rvalid,
  input  logic                      buf_rready,
  input  logic [PIXEL_SIZE-1:0]     buf_rdata
);

  localparam int AW = BUF_ADDR_WIDTH;
  localparam int XW = (CAMERA_HSIZE > 1) ? $clog2(CAMERA_HSIZE) : 1;
  localparam int YW = (CAMERA_VSIZE > 1) ? $clog2(CAMERA_VSIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(CAMERA_HSIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(CAMERA_VSIZE - 1);
  localparam logic [AW-1:0] H_A    = AW'(CAMERA_HSIZE);

  if (CAMERA_HSIZE * CAMERA_VSIZE > (1 << BUF_ADDR_WIDTH)) begin : g_size_err
    $error("image_buffer_master: frame does not fit in buffer address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            last_pix;
  logic            wr_all, rd_all, cap_pend;
  logic            wr_fire, rd_issue, out_fire, clr_cnt;
  logic [AW-1:0]   waddr_calc, raddr_calc;

  assign last_pix   = (x == X_LAST) && (y == Y_LAST);
  assign waddr_calc = AW'(y) * H_A + AW'(x);
`ifdef IMG_BUF_MIRROR_EN
  assign raddr_calc = AW'(y) * H_A + (H_A - AW'(1) - AW'(x));
`else
  assign raddr_calc = waddr_calc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pix_in_ready = 1'b0;
    wr_fire      = 1'b0;
    rd_issue     = 1'b0;
    out_fire     = 1'b0;
    clr_cnt      = 1'b0;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) begin
          clr_cnt   = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // wr_all gate stops a camera that keeps valid high from sneaking in an extra pixel
        pix_in_ready = ~buf_wvalid & buf_wready & ~wr_all;
        wr_fire      = pix_in_valid & pix_in_ready;
        if (wr_all && !buf_wvalid && buf_wready) begin
          clr_cnt   = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        rd_issue = ~buf_rvalid & buf_rready & ~cap_pend & ~pix_out_valid & ~rd_all;
        out_fire = pix_out_valid & pix_out_ready;
        if (out_fire && rd_all) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x             <= '0;
      y             <= '0;
      wr_all        <= 1'b0;
      rd_all        <= 1'b0;
      cap_pend      <= 1'b0;
      buf_wvalid    <= 1'b0;
      buf_waddr     <= '0;
      buf_wdata     <= '0;
      buf_rvalid    <= 1'b0;
      buf_raddr     <= '0;
      pix_out_valid <= 1'b0;
      pix_out_data  <= '0;
    end else begin
      buf_wvalid <= wr_fire;
      buf_rvalid <= rd_issue;
      if (wr_fire) begin
        buf_waddr <= waddr_calc;
        buf_wdata <= pix_in_data;
      end
      // buffer registers rdata on the edge that samples buf_rvalid; capture it one cycle later
      if (rd_issue) begin
        buf_raddr <= raddr_calc;
        cap_pend  <= 1'b1;
      end else if (cap_pend && !buf_rvalid) begin
        pix_out_data  <= buf_rdata;
        pix_out_valid <= 1'b1;
        cap_pend      <= 1'b0;
      end else if (out_fire) begin
        pix_out_valid <= 1'b0;
      end
      if (clr_cnt) begin
        x <= '0;
        y <= '0;
      end else if (wr_fire || rd_issue) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      if (state == S_IDLE) begin
        wr_all <= 1'b0;
        rd_all <= 1'b0;
      end else begin
        if (wr_fire && last_pix)  wr_all <= 1'b1;
        if (rd_issue && last_pix) rd_all <= 1'b1;
      end
    end
  end

endmodule
